// File: rtl/char_cursor_scheduler.sv
// Character FIFO plus cursor scheduler that issues glyphs and clears to the LCD datapath.
// Define CHAR_SCHED_AUTOCLEAR_EN to clear the screen on row overflow instead of wrapping to row 0.
module char_cursor_scheduler #(
    parameter int unsigned NUM_COLS   = 30,
    parameter int unsigned NUM_ROWS   = 20,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       globalReset,
    input  logic [6:0] asciiIn,
    input  logic       charValid,
    output logic       charAccept,
    input  logic       seqDone,
    output logic [6:0] charOut,
    output logic       charReady,
    output logic       lcdClear,
    output logic [4:0] rowOffset,
    output logic [5:0] colOffset,
    output logic       busy,
    output logic [3:0] fifoCount
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_CLEAR,
        S_CLRWAIT
    } state_t;

    state_t           state_q;
    logic [6:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]       count_q, count_d;
    logic [6:0]       char_q;
    logic [6:0]       charOut_q;
    logic             charReady_q, lcdClear_q;
    logic [4:0]       row_q;
    logic [5:0]       col_q;
    logic             push, pop, last_col, last_row;

    // No pop bypass: a full FIFO refuses even while the FSM pops.
    assign charAccept = (count_q != 4'(FIFO_DEPTH));
    assign push       = charValid && charAccept;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign last_col   = (col_q == 6'(NUM_COLS - 1));
    assign last_row   = (row_q == 5'(NUM_ROWS - 1));

    always_comb begin
        count_d = count_q + 4'(push) - 4'(pop);
    end

    always_ff @(posedge clock) begin
        if (globalReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= asciiIn;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (globalReset) begin
            state_q     <= S_IDLE;
            char_q      <= '0;
            charOut_q   <= '0;
            charReady_q <= 1'b0;
            lcdClear_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            charReady_q <= 1'b0;
            lcdClear_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        char_q  <= mem_q[rd_ptr_q];
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_IDLE;
                    if (char_q == 7'h0A || char_q == 7'h0D) begin
                        col_q <= '0;
                        if (last_row) begin
`ifdef CHAR_SCHED_AUTOCLEAR_EN
                            state_q    <= S_CLEAR;
                            lcdClear_q <= 1'b1;
`else
                            row_q <= '0;
`endif
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else if (char_q == 7'h08) begin
                        if (col_q != '0) begin
                            col_q <= col_q - 1'b1;
                        end else if (row_q != '0) begin
                            col_q <= 6'(NUM_COLS - 1);
                            row_q <= row_q - 1'b1;
                        end
                    end else if (char_q == 7'h0C) begin
                        state_q    <= S_CLEAR;
                        lcdClear_q <= 1'b1;
                    end else if (char_q >= 7'h20 && char_q <= 7'h7E) begin
                        state_q     <= S_ISSUE;
                        charOut_q   <= char_q;
                        charReady_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (seqDone) begin
                        state_q <= S_IDLE;
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
`ifdef CHAR_SCHED_AUTOCLEAR_EN
                                state_q    <= S_CLEAR;
                                lcdClear_q <= 1'b1;
`else
                                row_q <= '0;
`endif
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_q <= S_CLRWAIT;
                end
                S_CLRWAIT: begin
                    if (seqDone) begin
                        state_q <= S_IDLE;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign charOut   = charOut_q;
    assign charReady = charReady_q;
    assign lcdClear  = lcdClear_q;
    assign rowOffset = row_q;
    assign colOffset = col_q;
    assign fifoCount = count_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule
